mini_core_dmem_rsp: RTL and testbench
=====================================

# mini_core_dmem_rsp

Data-memory responder for the mini_core RV32I environment: accepts load/store requests from a core, or from the RV32I reference model acting as initiator, over a valid/ready request channel. It owns a byte-addressable little-endian memory and returns exactly one in-order response per request after a fixed pipeline latency, buffered against response back-pressure. It sits between the core's memory stage (or testbench initiator) and the checker/scoreboard.

## Interface
- ADDR_W, 12, byte-address bits decoded; memory size 2^ADDR_W bytes
- LATENCY, 2, accept-to-response cycles, legal 1..4
- RSP_DEPTH, 4, max outstanding requests (pipeline + buffer); must be >= LATENCY+1
- clk  in  1  clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_opcode  in  1  0 = read, 1 = write
- req_address  in  32  byte address, word-aligned
- req_byte_en  in  4  byte lanes to write; ignored on reads
- req_wr_data  in  32  write data, lane i = bits [8i+7:8i]
- req_tag  in  4  initiator tag, echoed
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rd_data  out  32  read data; 0 for writes
- rsp_tag  out  4  echoed tag
- rsp_err  out  1  request error (see Configuration)

## Operation
- Accept = req_valid && req_ready at a rising edge; pop = rsp_valid && rsp_ready.
- Word index = req_address[ADDR_W-1:2]; address[1:0] is not used for lane selection.
- Write: lanes with byte_en set update at the accept edge; byte_en = 0 leaves memory unchanged but still responds.
- Read: returns the full word as of the accept cycle, before that edge's update. A write accepted in cycle N is visible to a read accepted in N+1 or later.
- Responses are strictly in acceptance order, carrying tag, data and err through a LATENCY-stage pipeline into a RSP_DEPTH-entry FIFO with wrapping pointers.
- Outstanding counter: +1 on accept, -1 on pop, both in one cycle leaves it unchanged.
- req_ready = outstanding < RSP_DEPTH. It depends only on registered state, never combinationally on rsp_ready or req_valid.
- The FIFO can never overflow; any pop attempt while empty is impossible by construction.
- Reset mid-operation drops all in-flight and buffered responses and clears the counter. Memory contents are not reset and are retained.

## Timing
- Reset values: req_ready 0 while rst is high and 1 the cycle after; rsp_valid 0, rsp_rd_data 0, rsp_tag 0, rsp_err 0.
- Accept in cycle N, FIFO empty, rsp_ready high: rsp_valid is high in cycle N+LATENCY and popped at that edge.
- Throughput is 1 request/cycle sustained when rsp_ready is held high and RSP_DEPTH >= LATENCY+1.
- rsp_* is stable while rsp_valid && !rsp_ready. rsp_valid never drops without a pop, except under rst.
- Full (outstanding == RSP_DEPTH): req_ready is low. The cycle after a pop, req_ready is high again.

## Configuration
- MINI_CORE_DMEM_ERR_EN defined:
  - err = (req_address[31:ADDR_W] != 0) || (req_address[1:0] != 0).
  - An erroring write does not modify memory.
  - An erroring read returns 0.
  - rsp_err = 1 on the matching response.
- Undefined: rsp_err is tied 0, upper address bits and [1:0] are ignored, and every write is performed at the wrapped index.

## Structure
- mini_core_pkg holds:
  - the opcode enum t_dmem_op (DMEM_RD, DMEM_WR)
  - the request struct t_dmem_req (op, address, byte_en, wr_data, tag)
  - the response struct t_dmem_rsp (rd_data, tag, err)
- Sub-module mini_core_dmem_rsp_fifo: parameterised synchronous FIFO of t_dmem_rsp, depth RSP_DEPTH, with push/pop/empty/count.
- The top level holds the memory array, latency pipeline and credit counter.

## Test plan
- Write 0xDEADBEEF to 0x100 with byte_en 0xF (tag 1), then read 0x100 (tag 2): responses tag 1 with data 0, then tag 2 with data 0xDEADBEEF, err 0.
- Partial write of 0x000000AA to 0x100 with byte_en 0x1, then read: data 0xDEADBEAA. A byte_en 0x0 write followed by a read returns the same value unchanged.
- Back-to-back write 0x11111111 to 0x40 and read of 0x40 in consecutive cycles: read data 0x11111111. With LATENCY=2 and rsp_ready high, responses appear in cycles N+2 and N+3.
- Hold rsp_ready low while issuing 6 reads (RSP_DEPTH=4): exactly 4 accepted and req_ready low. Raise rsp_ready: tags return in order, and the remaining 2 are accepted.
- With MINI_CORE_DMEM_ERR_EN, write 0x12345678 to 0x1002 and then to 0x00010000: both return rsp_err=1 and memory is unchanged. Without the macro, the write to 0x00010000 lands at word 0.
- Assert rst for 1 cycle with 3 responses pending: rsp_valid is 0 and req_ready is 1 afterwards, and a subsequent read of 0x100 returns the pre-reset contents.

Source files
------------

// File: rtl/mini_core_pkg.sv
// Shared types for the mini_core data-memory responder: opcode, request and response records.
package mini_core_pkg;

  typedef enum logic {
    DMEM_RD = 1'b0,
    DMEM_WR = 1'b1
  } t_dmem_op;

  typedef struct packed {
    t_dmem_op    op;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [3:0]  tag;
  } t_dmem_req;

  typedef struct packed {
    logic [31:0] rd_data;
    logic [3:0]  tag;
    logic        err;
  } t_dmem_rsp;

  // Little-endian lane merge: lane i of wdata replaces lane i of old when be[i] is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mini_core_dmem_rsp_fifo.sv
// Synchronous response FIFO with wrapping pointers; head is valid whenever empty is low.
module mini_core_dmem_rsp_fifo
  import mini_core_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  t_dmem_rsp                    push_data,
  input  logic                         pop,
  output t_dmem_rsp                    head,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  t_dmem_rsp       store_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= push_data;
  end

  assign head  = store_q[rd_ptr_q];
  assign empty = (count == '0);

endmodule

// File: rtl/mini_core_dmem_rsp.sv
// Data-memory responder: byte-lane memory, fixed-latency response pipeline and credit counter.
// Define MINI_CORE_DMEM_ERR_EN to flag out-of-range or misaligned requests via rsp_err.
module mini_core_dmem_rsp
  import mini_core_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_opcode,
  input  logic [31:0] req_address,
  input  logic [3:0]  req_byte_en,
  input  logic [31:0] req_wr_data,
  input  logic [3:0]  req_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd_data,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err
);

  localparam int unsigned Words = 2 ** (ADDR_W - 2);
  localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW-1:0] MaxOut = CntW'(RSP_DEPTH);

  t_dmem_req         req;
  t_dmem_rsp         s0_rsp, push_rsp, head;
  logic              accept, pop, push, empty, err, do_write, ready_q;
  logic [ADDR_W-3:0] idx;
  logic [31:0]       mem [Words];
  logic [CntW-1:0]   cnt_q, cnt_d, fifo_count;

  assign req = '{op: t_dmem_op'(req_opcode), address: req_address, byte_en: req_byte_en,
                 wr_data: req_wr_data, tag: req_tag};

  assign accept = req_valid && ready_q && !rst;
  assign pop    = !empty && rsp_ready;
  assign idx    = req.address[ADDR_W-1:2];

`ifdef MINI_CORE_DMEM_ERR_EN
  assign err = (req.address[31:ADDR_W] != '0) || (req.address[1:0] != 2'b00);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req.address[31:ADDR_W], req.address[1:0]};
  assign err = 1'b0;
`endif

  assign do_write = accept && (req.op == DMEM_WR) && !err;

  // Memory is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= merge_bytes(mem[idx], req.wr_data, req.byte_en);
  end

  // Reads see the word before this edge's write.
  always_comb begin
    s0_rsp = '{rd_data: 32'h0, tag: req.tag, err: err};
    if ((req.op == DMEM_RD) && !err) s0_rsp.rd_data = mem[idx];
  end

  if (LATENCY == 1) begin : g_no_pipe
    assign push     = accept;
    assign push_rsp = s0_rsp;
  end else begin : g_pipe
    logic      pv_q [LATENCY-1];
    t_dmem_rsp pr_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) pv_q[i] <= 1'b0;
      end else begin
        pv_q[0] <= accept;
        for (int unsigned i = 1; i < LATENCY - 1; i++) pv_q[i] <= pv_q[i-1];
      end
      pr_q[0] <= s0_rsp;
      for (int unsigned i = 1; i < LATENCY - 1; i++) pr_q[i] <= pr_q[i-1];
    end

    assign push     = pv_q[LATENCY-2];
    assign push_rsp = pr_q[LATENCY-2];
  end

  mini_core_dmem_rsp_fifo #(
    .Depth (RSP_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Credit state is registered so req_ready never depends combinationally on rsp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d < MaxOut);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_count <= cnt_q);
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = !empty;
  assign rsp_rd_data = empty ? 32'h0 : head.rd_data;
  assign rsp_tag     = empty ? 4'h0 : head.tag;
  assign rsp_err     = empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_mini_core_dmem_rsp.sv
// Scoreboard bench for mini_core_dmem_rsp: a word-array model predicts each response at accept time.
module tb_mini_core_dmem_rsp;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned RSP_DEPTH = 4;
  localparam int unsigned WORDS     = 1 << (ADDR_W - 2);

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_opcode, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_address, req_wr_data, rsp_rd_data;
  logic [3:0]  req_byte_en, req_tag, rsp_tag;

  mini_core_dmem_rsp #(
    .ADDR_W    (ADDR_W),
    .LATENCY   (LATENCY),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_address (req_address),
    .req_byte_en (req_byte_en),
    .req_wr_data (req_wr_data),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rd_data (rsp_rd_data),
    .rsp_tag     (rsp_tag),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          acc_cyc;
    bit          lat_chk;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl [WORDS];
  int          checks = 0, passes = 0, cyc = 0, sent;
  bit          lat_chk_en = 0, rand_rdy = 0, stall_prev = 0;
  logic [36:0] prev_bus;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference: flat word array, little-endian lanes, response predicted from pre-write state.
  function automatic void model_accept();
    exp_t        e;
    bit          err;
    int unsigned w;
    err = 1'b0;
`ifdef MINI_CORE_DMEM_ERR_EN
    err = (req_address >= (32'd1 << ADDR_W)) || (req_address % 4 != 0);
`endif
    w         = (req_address >> 2) % WORDS;
    e.tag     = req_tag;
    e.err     = err;
    e.data    = 32'h0;
    e.acc_cyc = cyc;
    e.lat_chk = lat_chk_en;
    if (!err) begin
      if (req_opcode == 1'b0) e.data = mdl[w];
      else for (int b = 0; b < 4; b++)
        if (req_byte_en[b]) mdl[w][8*b +: 8] = req_wr_data[8*b +: 8];
    end
    sb.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid_hold", {31'h0, rsp_valid}, 32'h1);
        check("stall_data_hold", {rsp_rd_data ^ prev_bus[36:5]}, 32'h0);
        check("stall_tag_err_hold", {27'h0, rsp_tag, rsp_err}, {27'h0, prev_bus[4:0]});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: got response tag %h, required no response", rsp_tag);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rd_data", rsp_rd_data, mon_e.data);
          check("rsp_tag", {28'h0, rsp_tag}, {28'h0, mon_e.tag});
          check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
          if (mon_e.lat_chk) check("latency", cyc - mon_e.acc_cyc, LATENCY);
        end
      end
      stall_prev = rsp_valid && !rsp_ready;
      prev_bus   = {rsp_rd_data, rsp_tag, rsp_err};
    end
  end

  // Random back-pressure, changed just after the edge so the monitor sees a stable value.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic issue(input logic op, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [3:0] t);
    int n = 0;
    req_valid = 1'b1; req_opcode = op; req_address = a;
    req_byte_en = be; req_wr_data = d; req_tag = t;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL issue_timeout: got req_ready=0 for 50 cycles, required 1");
      req_valid = 1'b0;
    end else begin
      model_accept();
      @(negedge clk);
    end
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 rsp_ready = v;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    set_rdy(1'b1);
    while ((sb.size() != 0 || rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || rsp_valid) begin
      checks++;
      $display("FAIL drain_timeout: got %0d responses pending, required 0", sb.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_opcode = 1'b0;
    req_address = '0; req_byte_en = '0; req_wr_data = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", {31'h0, req_ready}, 32'h0);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_rd_data", rsp_rd_data, 32'h0);
    check("reset_rsp_tag_err", {27'h0, rsp_tag, rsp_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_req_ready", {31'h0, req_ready}, 32'h1);

    // Fill the whole memory with a known pattern.
    set_rdy(1'b1);
    for (int w = 0; w < WORDS; w++)
      issue(1'b1, w * 4, 4'hF, (w * 32'h01010101) ^ 32'hA5A5_5A5A, 4'(w));
    drain();

    issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 4'd1);
    issue(1'b0, 32'h100, 4'h0, 32'h0, 4'd2);
    issue(1'b1, 32'h100, 4'h1, 32'h000000AA, 4'd3);
    issue(1'b0, 32'h100, 4'h0, 32'h0, 4'd4);
    issue(1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 4'd5);
    issue(1'b0, 32'h100, 4'h0, 32'h0, 4'd6);
    drain();

    // Write then read in consecutive cycles, with exact-latency checking.
    lat_chk_en = 1'b1;
    issue(1'b1, 32'h40, 4'hF, 32'h11111111, 4'd7);
    issue(1'b0, 32'h40, 4'h0, 32'h0, 4'd8);
    req_valid  = 1'b0;
    lat_chk_en = 1'b0;
    drain();

    // Back-pressure: six reads offered with rsp_ready low.
    set_rdy(1'b0);
    sent = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_opcode = 1'b0; req_address = 32'h200 + 4 * sent;
      req_byte_en = 4'h0; req_tag = 4'(sent + 9);
      if (req_ready) begin
        model_accept();
        sent++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp_accepted", sent, RSP_DEPTH);
    check("bp_req_ready_low", {31'h0, req_ready}, 32'h0);
    set_rdy(1'b1);
    while (sent < 6) begin
      issue(1'b0, 32'h200 + 4 * sent, 4'h0, 32'h0, 4'(sent + 9));
      sent++;
    end
    drain();

    // Out-of-range and misaligned writes.
    issue(1'b1, 32'h0000_1002, 4'hF, 32'h12345678, 4'd1);
    issue(1'b1, 32'h0001_0000, 4'hF, 32'h12345678, 4'd2);
    issue(1'b0, 32'h0, 4'h0, 32'h0, 4'd3);
    issue(1'b0, 32'h4, 4'h0, 32'h0, 4'd4);
    drain();

    // Reset with responses pending; memory must survive.
    set_rdy(1'b0);
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h300 + 4 * i, 4'h0, 32'h0, 4'(i));
    req_valid = 1'b0;
    pulse_reset();
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_req_ready_in_reset_cycle", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    check("rst_req_ready_after", {31'h0, req_ready}, 32'h1);
    check("rst_rsp_valid_after", {31'h0, rsp_valid}, 32'h0);
    set_rdy(1'b1);
    issue(1'b0, 32'h100, 4'h0, 32'h0, 4'd5);
    drain();

    // Randomized traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 31)) * 4;
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F003);
      issue(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, 4'(i));
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    rand_rdy  = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
